keypad_scanner: RTL and testbench

- Input-side counterpart to the LED/seven-segment display path: scans a 4x4 matrix keypad and reports debounced key presses as 4-bit hex codes.
- Drives one column low at a time and reads the active-low rows through a synchronizer.
- Debounces press and release, then emits exactly one key_valid pulse per physical press.
- Feeds the display/datapath logic that previously took switch inputs.

---
 rtl/keypad_scanner.sv | 88 ++++++++
 tb/tb_keypad_scanner.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad and emits debounced hex key codes
module keypad_scanner #(
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);
  localparam int SW = SCAN_CYCLES > 1 ? $clog2(SCAN_CYCLES) : 1;
  localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SW-1:0] S_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  // nibble index is {row, column}: rows 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
  localparam logic [63:0] KEY_MAP = 64'hDF0EC987B654A321;
  typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_RELEASE} state_t;
  state_t        state;
  logic [3:0]    rs_m, rs, pat, code;
  logic [1:0]    idx, row;
  logic [SW-1:0] scnt;
  logic [DW-1:0] dcnt;
  assign cols = ~(4'b0001 << idx);
  always_comb begin
    row  = !pat[0] ? 2'd0 : !pat[1] ? 2'd1 : !pat[2] ? 2'd2 : 2'd3;
    code = KEY_MAP[{row, idx, 2'b00} +: 4];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SCAN;
      rs_m      <= 4'hF;
      rs        <= 4'hF;
      pat       <= 4'hF;
      idx       <= 2'd0;
      scnt      <= '0;
      dcnt      <= '0;
      key       <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      rs_m      <= rows;
      rs        <= rs_m;
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (scnt != S_LAST) scnt <= scnt + 1'b1;
          else begin
            scnt <= '0;
            dcnt <= '0;
            if (rs != 4'hF) begin
              pat   <= rs;
              state <= DEB_PRESS;
            end else idx <= idx + 1'b1;
          end
        end
        DEB_PRESS: begin
          if (rs != pat) begin
            state <= SCAN;
            idx   <= idx + 1'b1;
          end else if (dcnt == D_LAST) begin
            state     <= HELD;
            key       <= code;
            key_valid <= 1'b1;
            key_held  <= 1'b1;
          end else dcnt <= dcnt + 1'b1;
        end
        HELD: begin
          if (rs == 4'hF) begin
            dcnt  <= '0;
            state <= DEB_RELEASE;
          end
        end
        DEB_RELEASE: begin
          if (rs != 4'hF) dcnt <= '0;
          else if (dcnt == D_LAST) begin
            state    <= SCAN;
            key_held <= 1'b0;
            idx      <= idx + 1'b1;
          end else dcnt <= dcnt + 1'b1;
        end
        default: state <= SCAN;
      endcase
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad matrix model plus a procedural scanner reference checked every cycle
module tb_keypad_scanner;
  localparam int SC = 4;
  localparam int DB = 8;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] rows, cols, key;
  logic key_valid, key_held;
  logic [15:0] pk = '0;
  int total = 0, bad = 0, npulse = 0;
  logic [3:0] last_key = 4'h0;
  logic prev_v = 1'b0;
  int codes [16] = '{1, 2, 3, 'hA, 4, 5, 6, 'hB, 7, 8, 9, 'hC, 'hE, 0, 'hF, 'hD};
  int col_seq [5] = '{'hE, 'hD, 'hB, 'h7, 'hE};
  logic [1:0] m_idx;
  logic [3:0] m_key, m_cols, sync0, sync1;
  logic m_valid, m_held;
  int m_phase;
  bit abort;

  function automatic logic [3:0] rows_for(logic [3:0] cl, logic [15:0] p);
    logic [3:0] v;
    v = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!cl[c] && p[r*4+c]) v[r] = 1'b0;
    return v;
  endfunction

  function automatic int lowest(logic [3:0] p);
    for (int r = 0; r < 4; r++) if (!p[r]) return r;
    return 3;
  endfunction

  assign rows = rows_for(cols, pk);
  assign m_cols = ~(4'b0001 << m_idx);
  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_CYCLES(SC), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .rows(rows), .cols(cols),
    .key(key), .key_valid(key_valid), .key_held(key_held)
  );

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idx = 2'd0; m_key = 4'h0; m_valid = 1'b0; m_held = 1'b0;
    m_phase = 0; sync0 = 4'hF; sync1 = 4'hF;
  endtask

  // one clock of the reference: returns the synchronized row pattern the scanner decides on
  task automatic step(output logic [3:0] seen);
    @(posedge clk or negedge reset);
    seen = 4'hF;
    if (!reset) begin
      model_reset();
      abort = 1'b1;
      return;
    end
    m_valid = 1'b0;
    seen = sync1;
    sync1 = sync0;
    sync0 = rows_for(m_cols, pk);
  endtask

  initial begin : model
    logic [3:0] seen, pat;
    int run;
    bit ok;
    model_reset();
    forever begin
      wait (reset);
      abort = 1'b0;
      while (!abort) begin
        m_phase = 0;
        for (int d = 0; d < SC && !abort; d++) step(seen);
        if (abort) break;
        if (seen == 4'hF) begin m_idx++; continue; end
        pat = seen; m_phase = 1; ok = 1'b1;
        for (int d = 0; d < DB && ok && !abort; d++) begin
          step(seen);
          ok = (seen == pat);
        end
        if (abort) break;
        if (!ok) begin m_idx++; continue; end
        m_key = 4'(codes[lowest(pat)*4 + int'(m_idx)]);
        m_valid = 1'b1; m_held = 1'b1; m_phase = 2;
        do step(seen); while (seen != 4'hF && !abort);
        if (abort) break;
        m_phase = 3; run = 0;
        while (run < DB && !abort) begin
          step(seen);
          run = (seen == 4'hF) ? run + 1 : 0;
        end
        if (abort) break;
        m_held = 1'b0; m_idx++;
      end
    end
  end

  always @(negedge clk) begin
    chk("cols", int'(cols), int'(m_cols));
    chk("key", int'(key), int'(m_key));
    chk("key_valid", int'(key_valid), int'(m_valid));
    chk("key_held", int'(key_held), int'(m_held));
    chk("valid_twice", int'(key_valid & prev_v), 0);
    if (key_valid) begin npulse++; last_key = key; end
    prev_v = key_valid;
  end

  task automatic cyc(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  initial begin
    int b, k, dur;
    bit bouncy, hit;
    cyc(3);
    chk("rst_cols", int'(cols), 'hE);
    chk("rst_key", int'(key), 0);
    chk("rst_held", int'(key_held), 0);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("scan_cols", int'(cols), col_seq[i]);
      cyc(SC);
    end
    chk("idle_pulses", npulse, 0);
    b = npulse; pk[5] = 1'b1; cyc(40);
    chk("k5_pulses", npulse - b, 1);
    chk("k5_key", int'(last_key), 5);
    chk("k5_held", int'(key_held), 1);
    pk = '0; cyc(30);
    chk("k5_released", int'(key_held), 0);
    chk("k5_total", npulse - b, 1);
    b = npulse;
    for (int t = 0; t < 10; t++) begin pk[3] = ~pk[3]; cyc(3); end
    chk("bounce_quiet", npulse - b, 0);
    pk[3] = 1'b1; cyc(40);
    chk("bounce_pulses", npulse - b, 1);
    chk("bounce_key", int'(last_key), 'hA);
    pk = '0; cyc(30);
    b = npulse; pk[12] = 1'b1; cyc(40);
    chk("star_pulses", npulse - b, 1);
    chk("star_key", int'(last_key), 'hE);
    pk[2] = 1'b1; cyc(30);
    chk("second_ignored", npulse - b, 1);
    pk[12] = 1'b0; cyc(4); pk[2] = 1'b0; cyc(30);
    chk("second_no_pulse", npulse - b, 1);
    pk[2] = 1'b1; cyc(40);
    chk("repress_pulses", npulse - b, 2);
    chk("repress_key", int'(last_key), 3);
    pk = '0; cyc(30);
    b = npulse; pk[9] = 1'b1; cyc(40);
    chk("k8_key", int'(last_key), 8);
    pk = '0; cyc(5); pk[9] = 1'b1; cyc(2); pk[9] = 1'b0; cyc(9);
    chk("glitch_still_held", int'(key_held), 1);
    cyc(1);
    chk("glitch_dropped", int'(key_held), 0);
    chk("glitch_pulses", npulse - b, 1);
    cyc(20);
    b = npulse; pk[10] = 1'b1; hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      if (m_phase == 1) hit = 1'b1; else cyc(1);
    end
    chk("reach_press_debounce", int'(hit), 1);
    cyc(3);
    reset = 1'b0; #1;
    chk("midrst_cols", int'(cols), 'hE);
    chk("midrst_key", int'(key), 0);
    chk("midrst_valid", int'(key_valid), 0);
    chk("midrst_held", int'(key_held), 0);
    cyc(3); reset = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      if (npulse != b) hit = 1'b1; else cyc(1);
    end
    chk("after_rst_pulse_seen", int'(hit), 1);
    chk("after_rst_key", int'(last_key), 9);
    chk("after_rst_pulses", npulse - b, 1);
    pk = '0; cyc(30);
    for (int it = 0; it < 60; it++) begin
      k = int'($urandom_range(0, 15));
      dur = int'($urandom_range(1, 40));
      bouncy = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) pk[int'($urandom_range(0, 15))] = 1'b1;
      for (int t = 0; t < dur; t++) begin
        pk[k] = bouncy ? 1'($urandom_range(0, 1)) : 1'b1;
        cyc(1);
      end
      if ($urandom_range(0, 9) == 0) begin reset = 1'b0; cyc(2); reset = 1'b1; end
      pk = '0;
      cyc(int'($urandom_range(1, 30)));
    end
    cyc(40);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
